build_block: RTL

- Byte-to-block assembler; the inverse of our block-to-byte streamer.
- Collects NUM_BYTES serial bytes into one packed block, then presents the whole block with a valid/ready handshake.
- Byte order: the first byte received lands at the highest index (block_out[NUM_BYTES-1]) and the last at index 0. A block streamed out by the streamer and fed into build_block is therefore reconstructed unchanged.
- Sits between a byte-serial source (cipher/stream path) and block-level consumers.

---
 rtl/build_block.sv | 100 ++++++++++
 1 files changed

// File: rtl/build_block.sv
// ============================================================================
// Module   : build_block
// Purpose  : Collects NUM_BYTES serial bytes into one packed block, first byte
//            at the highest index, then presents it with a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module build_block #(
   parameter int NUM_BYTES = 16,
   parameter int BYTE_W    = 8
) (
   input  logic                                clk_in,
   input  logic                                rst_in,
   input  logic                                start,
   input  logic [BYTE_W-1:0]                   data_in,
   input  logic                                valid_in,
   output logic                                ready_out,
   output logic [NUM_BYTES-1:0][BYTE_W-1:0]    block_out,
   output logic                                block_valid_out,
   input  logic                                block_ready_in,
   output logic [$clog2(NUM_BYTES+1)-1:0]      byte_count_out
);

   localparam int CW    = $clog2(NUM_BYTES+1);
   localparam int IDX_W = $clog2(NUM_BYTES);
   localparam logic [CW-1:0] LAST_COUNT = CW'(NUM_BYTES-1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t                              state, state_nxt;
   logic [CW-1:0]                       count, count_nxt;
   logic [NUM_BYTES-1:0][BYTE_W-1:0]    block, block_nxt;
   logic [IDX_W-1:0]                    wr_idx;

   // Only evaluated in FILL, where count never exceeds NUM_BYTES-1.
   assign wr_idx = IDX_W'(NUM_BYTES-1) - count[IDX_W-1:0];

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state <= IDLE;
         count <= '0;
         block <= '0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         block <= block_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      count_nxt = count;
      block_nxt = block;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = FILL;
               count_nxt = '0;
               block_nxt = '0;
            end
         end
         FILL: begin
            // A restart discards any byte offered in the same cycle.
            if (start) begin
               count_nxt = '0;
               block_nxt = '0;
            end else if (valid_in) begin
               block_nxt[wr_idx] = data_in;
               count_nxt         = count + CW'(1);
               if (count == LAST_COUNT) state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (block_ready_in) begin
               if (start) begin
                  state_nxt = FILL;
                  count_nxt = '0;
                  block_nxt = '0;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign ready_out       = (state == FILL);
   assign block_valid_out = (state == HOLD);
   assign block_out       = block;
   assign byte_count_out  = count;

endmodule

`default_nettype wire
